// File: rtl/rename_regfile_pkg.sv
// rtl/rename_regfile_pkg.sv - shared constants for the rename register file
package rename_regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_WIDTH  = 5;
    localparam int ROB_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;

    localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
    localparam logic [REG_WIDTH-1:0]  ZERO_REG  = '0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
    localparam logic                  TRUE      = 1'b1;
    localparam logic                  FALSE     = 1'b0;

endpackage

// File: rtl/rename_regfile_read_port.sv
// rtl/rename_regfile_read_port.sv - combinational operand read with commit bypass
module rename_regfile_read_port
    import rename_regfile_pkg::*;
#(
    parameter int REG_COUNT = rename_regfile_pkg::REG_COUNT,
    parameter int REG_W     = REG_WIDTH,
    parameter int ROB_TAG_W = ROB_WIDTH,
    parameter int DATA_W    = DATA_WIDTH
) (
    input  logic [REG_W-1:0]     query_reg,
    input  logic [DATA_W-1:0]    value_arr [REG_COUNT],
    input  logic [ROB_TAG_W-1:0] tag_arr   [REG_COUNT],
    input  logic [REG_W-1:0]     commit_reg,
    input  logic [ROB_TAG_W-1:0] commit_tag,
    input  logic [DATA_W-1:0]    commit_value,
    output logic [DATA_W-1:0]    query_value,
    output logic [ROB_TAG_W-1:0] query_tag
);

    always_comb begin
        query_value = ZERO_DATA;
        query_tag   = ZERO_ROB;
        if (query_reg != ZERO_REG) begin
            // Only the producer we are waiting on may satisfy us early.
            if (query_reg == commit_reg && tag_arr[query_reg] == commit_tag) begin
                query_value = commit_value;
            end else begin
                query_value = value_arr[query_reg];
                query_tag   = tag_arr[query_reg];
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// rtl/rename_regfile.sv - architectural register file with per-register ROB rename tags
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int REG_COUNT = rename_regfile_pkg::REG_COUNT,
    parameter int REG_W     = REG_WIDTH,
    parameter int ROB_TAG_W = ROB_WIDTH,
    parameter int DATA_W    = DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_W-1:0]     rename_reg,
    input  logic [ROB_TAG_W-1:0] rename_tag,
    input  logic [REG_W-1:0]     commit_reg,
    input  logic [ROB_TAG_W-1:0] commit_tag,
    input  logic [DATA_W-1:0]    commit_value,
    input  logic                 flush,
    input  logic [REG_W-1:0]     query_reg1,
    input  logic [REG_W-1:0]     query_reg2,
    output logic [DATA_W-1:0]    query_value1,
    output logic [ROB_TAG_W-1:0] query_tag1,
    output logic [DATA_W-1:0]    query_value2,
    output logic [ROB_TAG_W-1:0] query_tag2,
    output logic [REG_W:0]       pending_count
);

    logic [DATA_W-1:0]    value_arr [REG_COUNT];
    logic [ROB_TAG_W-1:0] tag_arr   [REG_COUNT];

    logic rename_active;
    logic cnt_inc;
    logic cnt_dec;

    // Count bookkeeping mirrors the tag writes below: rename wins over a same-register clear.
    always_comb begin
        rename_active = FALSE;
        cnt_inc       = FALSE;
        cnt_dec       = FALSE;
        if (rename_tag != ZERO_ROB && rename_reg != ZERO_REG && !flush) begin
            rename_active = TRUE;
            if (tag_arr[rename_reg] == ZERO_ROB) cnt_inc = TRUE;
        end
        if (commit_reg != ZERO_REG && commit_tag != ZERO_ROB &&
            tag_arr[commit_reg] == commit_tag &&
            !(rename_active && rename_reg == commit_reg)) begin
            cnt_dec = TRUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                value_arr[r] <= ZERO_DATA;
                tag_arr[r]   <= ZERO_ROB;
            end
            pending_count <= '0;
        end else begin
            if (commit_reg != ZERO_REG) begin
                value_arr[commit_reg] <= commit_value;
                if (tag_arr[commit_reg] == commit_tag) tag_arr[commit_reg] <= ZERO_ROB;
            end
            if (flush) begin
                for (int r = 0; r < REG_COUNT; r++) tag_arr[r] <= ZERO_ROB;
                pending_count <= '0;
            end else begin
                if (rename_active) tag_arr[rename_reg] <= rename_tag;
                case ({cnt_inc, cnt_dec})
                    2'b10:   pending_count <= pending_count + 1'b1;
                    2'b01:   pending_count <= pending_count - 1'b1;
                    default: pending_count <= pending_count;
                endcase
            end
        end
    end

    logic [DATA_W-1:0]    rp1_value, rp2_value;
    logic [ROB_TAG_W-1:0] rp1_tag, rp2_tag;

    rename_regfile_read_port #(
        .REG_COUNT(REG_COUNT), .REG_W(REG_W), .ROB_TAG_W(ROB_TAG_W), .DATA_W(DATA_W)
    ) u_read_port1 (
        .query_reg   (query_reg1),
        .value_arr   (value_arr),
        .tag_arr     (tag_arr),
        .commit_reg  (commit_reg),
        .commit_tag  (commit_tag),
        .commit_value(commit_value),
        .query_value (rp1_value),
        .query_tag   (rp1_tag)
    );

    rename_regfile_read_port #(
        .REG_COUNT(REG_COUNT), .REG_W(REG_W), .ROB_TAG_W(ROB_TAG_W), .DATA_W(DATA_W)
    ) u_read_port2 (
        .query_reg   (query_reg2),
        .value_arr   (value_arr),
        .tag_arr     (tag_arr),
        .commit_reg  (commit_reg),
        .commit_tag  (commit_tag),
        .commit_value(commit_value),
        .query_value (rp2_value),
        .query_tag   (rp2_tag)
    );

    // While reset is held the bypass must not leak a commit value onto the ports.
    assign query_value1 = rst ? ZERO_DATA : rp1_value;
    assign query_tag1   = rst ? ZERO_ROB  : rp1_tag;
    assign query_value2 = rst ? ZERO_DATA : rp2_value;
    assign query_tag2   = rst ? ZERO_ROB  : rp2_tag;

endmodule
